// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with pixel-rate clock enable
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic [10:0] CurrentX,
  output logic [10:0] CurrentY,
  output logic        HBlank,
  output logic        VBlank,
  output logic        HSync,
  output logic        VSync,
  output logic        PixelTick,
  output logic        FrameStart
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  logic [DIV_W-1:0] div, div_nxt;
  logic [10:0]      x_nxt, y_nxt;
  logic             adv, frame_wrap;

  // CurrentX/CurrentY are themselves the raster state, so outputs never skew
  always_comb begin
    adv        = ENABLE && (div == DIV_LAST);
    div_nxt    = div;
    x_nxt      = CurrentX;
    y_nxt      = CurrentY;
    frame_wrap = 1'b0;
    if (ENABLE)
      div_nxt = adv ? '0 : div + 1'b1;
    if (adv) begin
      if (CurrentX == H_LAST) begin
        x_nxt = '0;
        if (CurrentY == V_LAST) begin
          y_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          y_nxt = CurrentY + 11'd1;
        end
      end else begin
        x_nxt = CurrentX + 11'd1;
      end
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      div        <= '0;
      CurrentX   <= '0;
      CurrentY   <= '0;
      HBlank     <= 1'b0;
      VBlank     <= 1'b0;
      HSync      <= ~HS_ON;
      VSync      <= ~VS_ON;
      PixelTick  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      div        <= div_nxt;
      CurrentX   <= x_nxt;
      CurrentY   <= y_nxt;
      HBlank     <= (x_nxt >= H_ACT_END);
      VBlank     <= (y_nxt >= V_ACT_END);
      HSync      <= ((x_nxt >= H_SYNC_BEG) && (x_nxt < H_SYNC_END)) ? HS_ON : ~HS_ON;
      VSync      <= ((y_nxt >= V_SYNC_BEG) && (y_nxt < V_SYNC_END)) ? VS_ON : ~VS_ON;
      PixelTick  <= adv;
      FrameStart <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - three raster configurations against a pixel-count reference model
module tb_vga_timing_gen;

  // instance 0: defaults; 1: small raster, CLK_DIV=3; 2: small raster, CLK_DIV=1, negative syncs
  localparam int CD  [3] = '{2, 3, 1};
  localparam int HA  [3] = '{800, 16, 12};
  localparam int HFP [3] = '{56, 3, 2};
  localparam int HS  [3] = '{120, 5, 4};
  localparam int HBP [3] = '{64, 4, 3};
  localparam int VA  [3] = '{600, 10, 8};
  localparam int VFP [3] = '{37, 2, 1};
  localparam int VS  [3] = '{6, 3, 2};
  localparam int VBP [3] = '{23, 2, 2};
  localparam int HP  [3] = '{1, 1, 0};
  localparam int VP  [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [3];
  logic [10:0] cx   [3];
  logic [10:0] cy   [3];
  logic        hb   [3];
  logic        vb   [3];
  logic        hsy  [3];
  logic        vsy  [3];
  logic        pt   [3];
  logic        fs   [3];

  longint ecnt   [3];
  bit     m_tick [3];
  bit     m_fs   [3];
  int     nvec = 0;
  int     nerr = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(en[0]),
    .CurrentX(cx[0]), .CurrentY(cy[0]), .HBlank(hb[0]), .VBlank(vb[0]),
    .HSync(hsy[0]), .VSync(vsy[0]), .PixelTick(pt[0]), .FrameStart(fs[0])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2), .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut_b (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(en[1]),
    .CurrentX(cx[1]), .CurrentY(cy[1]), .HBlank(hb[1]), .VBlank(vb[1]),
    .HSync(hsy[1]), .VSync(vsy[1]), .PixelTick(pt[1]), .FrameStart(fs[1])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(12), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut_c (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(en[2]),
    .CurrentX(cx[2]), .CurrentY(cy[2]), .HBlank(hb[2]), .VBlank(vb[2]),
    .HSync(hsy[2]), .VSync(vsy[2]), .PixelTick(pt[2]), .FrameStart(fs[2])
  );

  function automatic int htot(int i);
    return HA[i] + HFP[i] + HS[i] + HBP[i];
  endfunction

  function automatic int vtot(int i);
    return VA[i] + VFP[i] + VS[i] + VBP[i];
  endfunction

  // Raster position is simply the number of pixels elapsed since reset, folded into the frame
  function automatic int exp_x(int i);
    return int'((ecnt[i] / CD[i]) % htot(i));
  endfunction

  function automatic int exp_y(int i);
    return int'(((ecnt[i] / CD[i]) / htot(i)) % vtot(i));
  endfunction

  function automatic logic [27:0] expected(int i);
    int  x, y;
    bit  hs_act, vs_act;
    x = exp_x(i);
    y = exp_y(i);
    hs_act = (x >= HA[i] + HFP[i]) && (x < HA[i] + HFP[i] + HS[i]);
    vs_act = (y >= VA[i] + VFP[i]) && (y < VA[i] + VFP[i] + VS[i]);
    return {11'(x), 11'(y), x >= HA[i], y >= VA[i],
            hs_act ? (HP[i] != 0) : (HP[i] == 0),
            vs_act ? (VP[i] != 0) : (VP[i] == 0),
            m_tick[i], m_fs[i]};
  endfunction

  task automatic update_model(int i);
    if (rst) begin
      ecnt[i]   = 0;
      m_tick[i] = 1'b0;
      m_fs[i]   = 1'b0;
    end else if (en[i]) begin
      ecnt[i]   = ecnt[i] + 1;
      m_tick[i] = (ecnt[i] % CD[i]) == 0;
      m_fs[i]   = m_tick[i] && (((ecnt[i] / CD[i]) % (htot(i) * vtot(i))) == 0);
    end else begin
      m_tick[i] = 1'b0;
      m_fs[i]   = 1'b0;
    end
  endtask

  task automatic step();
    logic [27:0] obs, exp;
    @(posedge clk);
    for (int i = 0; i < 3; i++) update_model(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      obs = {cx[i], cy[i], hb[i], vb[i], hsy[i], vsy[i], pt[i], fs[i]};
      exp = expected(i);
      nvec++;
      assert (obs === exp) else begin
        nerr++;
        $error("FAIL raster%0d t=%0t obs=%h exp=%h", i, $time, obs, exp);
      end
    end
  endtask

  task automatic set_en(logic v);
    for (int i = 0; i < 3; i++) en[i] = v;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ecnt[i] = 0; m_tick[i] = 1'b0; m_fs[i] = 1'b0;
    end
    rst = 1'b1;
    set_en(1'b1);
    repeat (3) step();

    // run the default raster up to pixel 799, pause 10 clocks, then cross into the blanking
    rst = 1'b0;
    for (int k = 0; k < 4000 && exp_x(0) != 799; k++) step();
    set_en(1'b0);
    repeat (10) step();
    set_en(1'b1);
    repeat (1500) step();

    // one-clock reset in mid-frame
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (200) step();

    // random enables with occasional resets
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < 3; i++) en[i] = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    // uninterrupted run covering several frames of the small rasters
    rst = 1'b0;
    set_en(1'b1);
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
